// File: rtl/kbd_arb_pkg.sv
// Shared types for the keyboard event arbiter: FSM state, key event layout and widths.
package kbd_arb_pkg;

  localparam int EVT_W = 10;
  localparam int KEY_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       pressed;
    logic [8:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr+1, wrapping.
module kbd_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kbd_event_arbiter.sv
// Round-robin arbiter sharing the ps2_key event port between NUM_REQ sources, with a guard gap per slot.
// Optional held-key release on flush is built when KBD_FLUSH_EN is defined.
module kbd_event_arbiter
  import kbd_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 2,
  parameter int  GAP_CYCLES = 16,
  parameter int  GAP_W      = 8,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*EVT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_flush,
  output logic [KEY_W-1:0]         ps2_key,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  kbd_evt_t         evt_q, evt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;

  kbd_evt_t           req_evt [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               flush_any;
  logic [8:0]         flush_code;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_evt[i] = req_data[i*EVT_W +: EVT_W];
    end
  end

  kbd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    evt_d     = evt_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // A pending flush owns the slot; no requester is offered ready meanwhile.
        if (flush_any) begin
          evt_d   = '{pressed: 1'b0, code: flush_code};
          state_d = EMIT;
        end else if (pick_any) begin
          req_ready = pick_grant;
          evt_d     = req_evt[pick_idx];
          grant_d   = pick_idx;
          ptr_d     = pick_idx;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        key_d   = {~key_q[KEY_W-1], evt_q};
        cnt_d   = GAP_W'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      evt_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      evt_q   <= evt_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KBD_FLUSH_EN
  logic [NUM_REQ-1:0] held_q, held_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [8:0]         hcode_q [NUM_REQ];
  logic [8:0]         hcode_d [NUM_REQ];
  logic [IDX_W-1:0]   flush_idx;
  logic               flush_slot;

  always_comb begin
    flush_any = |pend_q;
    flush_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) flush_idx = IDX_W'(i);
    end
    flush_code = hcode_q[flush_idx];
    flush_slot = (state_q == IDLE) && flush_any;
  end

  // Per requester: apply this cycle's accept, then the slot's own flush, then a new flush request.
  always_comb begin
    held_d  = held_q;
    pend_d  = pend_q;
    hcode_d = hcode_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        if (req_evt[i].pressed) begin
          held_d[i]  = 1'b1;
          hcode_d[i] = req_evt[i].code;
        end else if (req_evt[i].code == hcode_q[i]) begin
          held_d[i] = 1'b0;
        end
      end
      if (flush_slot && (flush_idx == IDX_W'(i))) begin
        held_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end
      if (req_flush[i] && held_d[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
      pend_q <= '0;
      // NOTE: the code array is tiny and read on flush, so it is reset rather than left unknown.
      for (int i = 0; i < NUM_REQ; i++) hcode_q[i] <= '0;
    end else begin
      held_q  <= held_d;
      pend_q  <= pend_d;
      hcode_q <= hcode_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = ^req_flush;
  assign flush_any    = 1'b0;
  assign flush_code   = '0;
`endif

  assign ps2_key  = key_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_kbd_event_arbiter.sv
// Self-checking bench for kbd_event_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_kbd_event_arbiter;

  localparam int N   = 2;
  localparam int GAP = 16;
`ifdef KBD_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N-1:0]           req_valid;
  logic [N*10-1:0]        req_data;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           req_flush;
  logic [10:0]            ps2_key;
  logic [$clog2(N)-1:0]   grant_id;
  logic                   busy;

  always #5 clk = ~clk;

  kbd_event_arbiter #(
    .NUM_REQ    (N),
    .GAP_CYCLES (GAP),
    .GAP_W      (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_flush (req_flush),
    .ps2_key   (ps2_key),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus sources: per-requester queue of events still to be offered.
  logic [9:0] src_q [N][$];
  int         valid_pct = 100;

  // Slot-level reference model.
  int         m_busy_left = 0;
  int         m_pend_cnt  = 0;
  logic [9:0] m_pend_evt  = '0;
  logic [10:0] m_key      = '0;
  int         m_ptr       = 0;
  int         m_grant     = 0;
  int         m_slots     = 0;
  bit         m_held  [N];
  logic [8:0] m_hcode [N];
  bit         m_fpend [N];

  // Observations of the DUT.
  int   cyc       = 0;
  int   toggles   = 0;
  int   busy_cnt  = 0;
  int   r0_cnt    = 0;
  logic prev_tog  = 1'b0;
  int   acc_src [$];
  int   acc_cyc [$];
  logic [10:0] key_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_pend_cnt  = 0;
    m_key       = '0;
    m_ptr       = 0;
    m_grant     = 0;
    prev_tog    = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_held[i]  = 1'b0;
      m_hcode[i] = '0;
      m_fpend[i] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
        req_valid[i]        = 1'b1;
        req_data[i*10 +: 10] = src_q[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*10 +: 10] = 10'($urandom);
      end
    end
    req_flush = '0;
  endtask

  // One clock: check outputs against the model at negedge, advance the model across the posedge.
  task automatic step();
    int           pick;
    int           fidx;
    int           c;
    bit           fl;
    logic [N-1:0] exp_ready;
    logic [N-1:0] cur_flush;
    logic [9:0]   evt;
    @(negedge clk);
    fl = 1'b0; fidx = 0; pick = -1; exp_ready = '0;
    if (m_busy_left == 0) begin
      if (FLUSH_EN) begin
        for (int i = 0; i < N; i++) if (m_fpend[i] && !fl) begin fl = 1'b1; fidx = i; end
      end
      if (!fl) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (pick < 0 && req_valid[c]) pick = c;
        end
      end
    end
    if (pick >= 0) exp_ready[pick] = 1'b1;
    chk("ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_busy_left != 0));
    chk("ps2_key", 32'(ps2_key), 32'(m_key));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    if (ps2_key[10] !== prev_tog) begin
      toggles++;
      key_log.push_back(ps2_key);
      prev_tog = ps2_key[10];
    end
    if (busy === 1'b1) busy_cnt++;
    if (req_ready[0] === 1'b1) r0_cnt++;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1) begin
        acc_src.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    cur_flush = req_flush;
    @(posedge clk);
    cyc++;
    if (m_pend_cnt > 0) begin
      m_pend_cnt--;
      if (m_pend_cnt == 0) m_key = {~m_key[10], m_pend_evt};
    end
    if (m_busy_left > 0) m_busy_left--;
    if (fl) begin
      m_pend_evt    = {1'b0, m_hcode[fidx]};
      m_pend_cnt    = 1;
      m_busy_left   = GAP + 1;
      m_held[fidx]  = 1'b0;
      m_fpend[fidx] = 1'b0;
      m_slots++;
    end else if (pick >= 0) begin
      evt         = src_q[pick].pop_front();
      m_pend_evt  = evt;
      m_pend_cnt  = 1;
      m_busy_left = GAP + 1;
      m_ptr       = pick;
      m_grant     = pick;
      m_slots++;
      if (evt[9]) begin
        m_held[pick]  = 1'b1;
        m_hcode[pick] = evt[8:0];
      end else if (evt[8:0] == m_hcode[pick]) begin
        m_held[pick] = 1'b0;
      end
    end
    if (FLUSH_EN) begin
      for (int i = 0; i < N; i++) if (cur_flush[i] && m_held[i]) m_fpend[i] = 1'b1;
    end
    #1;
    drive_inputs();
  endtask

  initial begin
    int a0, b0, t0, k0, r0, s0, rem;
    model_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_flush = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key", 32'(ps2_key), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    reset_n = 1'b1;
    drive_inputs();

    // Single event from requester 0.
    a0 = acc_src.size(); b0 = busy_cnt; t0 = toggles;
    src_q[0].push_back(10'h01C);
    drive_inputs();
    repeat (40) step();
    chk("t1_accepts", 32'(acc_src.size() - a0), 32'd1);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd17);
    chk("t1_key", 32'(ps2_key), 32'h41C);
    chk("t1_toggles", 32'(toggles - t0), 32'd1);

    // Both requesters continuously valid: strict alternation starting with requester 1.
    a0 = acc_src.size(); t0 = toggles; k0 = key_log.size();
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(10'h210 + 10'(k));
      src_q[1].push_back(10'h220 + 10'(k));
    end
    drive_inputs();
    repeat (6 * (GAP + 2) + 4) step();
    for (int k = 0; k < 4; k++) chk($sformatf("t2_grant%0d", k), 32'(acc_src[a0 + k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    chk("t2_toggles", 32'(toggles - t0), 32'd6);
    for (int j = k0 + 1; j < key_log.size(); j++) chk("t2_distinct", 32'(key_log[j][9:0] != key_log[j-1][9:0]), 32'd1);

    // Requester 1 alone, back-to-back: one slot every GAP+2 cycles.
    a0 = acc_src.size(); t0 = toggles; r0 = r0_cnt;
    for (int k = 0; k < 5; k++) src_q[1].push_back(10'h230 + 10'(k));
    drive_inputs();
    repeat (5 * (GAP + 2) + 4) step();
    chk("t3_accepts", 32'(acc_src.size() - a0), 32'd5);
    for (int k = 1; k < 5; k++) chk("t3_spacing", 32'(acc_cyc[a0 + k] - acc_cyc[a0 + k - 1]), 32'(GAP + 2));
    chk("t3_toggles", 32'(toggles - t0), 32'd5);
    chk("t3_ready0", 32'(r0_cnt - r0), 32'd0);

    // Reset during the guard gap of a 'h175 press.
    src_q[1].push_back(10'h375);
    drive_inputs();
    repeat (5) step();
    chk("t4_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t4_key_rst", 32'(ps2_key), 32'h0);
    chk("t4_busy_rst", 32'(busy), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    a0 = acc_src.size();
    src_q[0].push_back(10'h033);
    drive_inputs();
    repeat (22) step();
    chk("t4_accepts", 32'(acc_src.size() - a0), 32'd1);
    chk("t4_key", 32'(ps2_key), 32'h433);

`ifdef KBD_FLUSH_EN
    // Held key released by flush ahead of a waiting requester; second flush does nothing.
    src_q[0].push_back(10'h229);
    drive_inputs();
    repeat (3) step();
    k0 = key_log.size();
    src_q[1].push_back(10'h25A);
    drive_inputs();
    req_flush[0] = 1'b1;
    step();
    repeat (45) step();
    chk("t5_events", 32'(key_log.size() - k0), 32'd2);
    chk("t5_release", 32'(key_log[k0][9:0]), 32'h029);
    chk("t5_req1", 32'(key_log[k0 + 1][9:0]), 32'h25A);
    k0 = key_log.size();
    req_flush[0] = 1'b1;
    step();
    repeat (25) step();
    chk("t5_second_flush", 32'(key_log.size() - k0), 32'd0);
`endif

    // Random traffic with random valid gaps against the model.
    valid_pct = 60;
    t0 = toggles; s0 = m_slots;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(10'($urandom));
    drive_inputs();
    rem = 16;
    for (int s = 0; s < 4000 && (rem > 0 || m_busy_left > 0); s++) begin
      step();
`ifdef KBD_FLUSH_EN
      for (int i = 0; i < N; i++) req_flush[i] = ($urandom_range(19) == 0);
`endif
      rem = 0;
      for (int i = 0; i < N; i++) rem += src_q[i].size();
    end
    repeat (4) step();
    chk("t6_drain", 32'(rem), 32'd0);
    chk("t6_event_count", 32'(toggles - t0), 32'(m_slots - s0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
